// File: rtl/key_expand.sv
// -----------------------------------------------------------------------------
// key_expand -- iterative AES-128 key schedule
//
// Expands one 128-bit cipher key into the eleven concatenated round keys
// (1408 bits), producing one round key per clock. The result drives the
// 1408-bit key bus of the AES round core. Decryption uses the same bus,
// because the round core applies InvMixColumns to middle-round keys itself.
//
// Ports:
//   i_Clk     clock, rising edge
//   i_Rst     asynchronous reset, active low
//   i_Key     cipher key, byte 0 = i_Key[127:120]; sampled on an accepted start
//   i_fStart  start request, accepted only in IDLE
//   o_Key     expanded key, round key r at [1407-128r : 1280-128r]
//   o_fBusy   high while EXPAND or DONE
//   o_fDone   one-cycle pulse, o_Key complete and stable
//
// Optional feature, macro KEY_EXPAND_CACHE_EN:
//   When defined, a start whose key equals the key already held in slot 0 of
//   a completed schedule skips the expansion and pulses o_fDone right away.
//   When undefined, every start runs the full 10-round expansion and neither
//   the valid flag nor the key comparator exists.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sub_byte -- AES SubBytes / InvSubBytes over a 128-bit state
//
// Ports:
//   i_Data      128-bit input, 16 independent bytes
//   i_fEncrypt  1 = forward S-box, 0 = inverse S-box
//   o_Data      128-bit substituted output
// -----------------------------------------------------------------------------
module sub_byte (
  input  logic [127:0] i_Data,
  input  logic         i_fEncrypt,
  output logic [127:0] o_Data
);

  // Byte x of each table lives at bits [2047-8x -: 8].
  localparam logic [2047:0] c_Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] c_InvSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      logic [7:0]  w_In;
      logic [10:0] w_Idx;
      assign w_In  = i_Data[8*gi +: 8];
      assign w_Idx = 11'd2047 - {w_In, 3'b000};
      assign o_Data[8*gi +: 8] = i_fEncrypt ? c_Sbox[w_Idx -: 8]
                                            : c_InvSbox[w_Idx -: 8];
    end
  endgenerate

endmodule

module key_expand (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [127:0]  i_Key,
  input  logic          i_fStart,
  output logic [1407:0] o_Key,
  output logic          o_fBusy,
  output logic          o_fDone
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} t_State;

  t_State       r_State;
  logic [3:0]   r_Round;
  logic [7:0]   r_Rcon;
  logic [127:0] r_Prev;     // last round key written, source of the next round
  logic         r_fBusy;
  logic         r_fDone;

  logic         w_Hit;
  logic         w_Load;
  logic [31:0]  w_W0, w_W1, w_W2, w_W3;
  logic [31:0]  w_Rot;
  logic [127:0] w_SubIn;
  logic [127:0] w_SubOut;
  logic [31:0]  w_T;
  logic [31:0]  w_N0, w_N1, w_N2, w_N3;
  logic [127:0] w_Next;
  logic [7:0]   w_RconNext;
  logic         w_unused_sub;

  // ---------------------------------------------------------------------------
  // Round function
  // ---------------------------------------------------------------------------
  assign {w_W0, w_W1, w_W2, w_W3} = r_Prev;
  assign w_Rot   = {w_W3[23:0], w_W3[31:24]};
  assign w_SubIn = {w_Rot, 96'h0};

  sub_byte u_sub_byte (
    .i_Data     (w_SubIn),
    .i_fEncrypt (1'b1),
    .o_Data     (w_SubOut)
  );

  // Only the top word of the shared SubByte instance carries data.
  assign w_unused_sub = ^w_SubOut[95:0];

  assign w_T    = w_SubOut[127:96] ^ {r_Rcon, 24'h0};
  assign w_N0   = w_W0 ^ w_T;
  assign w_N1   = w_N0 ^ w_W1;
  assign w_N2   = w_N1 ^ w_W2;
  assign w_N3   = w_N2 ^ w_W3;
  assign w_Next = {w_N0, w_N1, w_N2, w_N3};

  assign w_RconNext = {r_Rcon[6:0], 1'b0} ^ (r_Rcon[7] ? 8'h1B : 8'h00);

  // ---------------------------------------------------------------------------
  // Optional key cache: a repeat of the last completed key needs no work
  // ---------------------------------------------------------------------------
`ifdef KEY_EXPAND_CACHE_EN
  logic r_fValid;
  assign w_Hit = r_fValid && (i_Key == o_Key[1407:1280]);
`else
  assign w_Hit = 1'b0;
`endif

  assign w_Load = (r_State == IDLE) && i_fStart && !w_Hit;

  // ---------------------------------------------------------------------------
  // Round-key slots: slot 0 loads the cipher key, slot r the r-th round
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 11; gi++) begin : g_slot
      logic         w_We;
      logic [127:0] w_D;
      logic [127:0] r_Slot;

      if (gi == 0) begin : g_load
        assign w_We = w_Load;
        assign w_D  = i_Key;
      end else begin : g_round
        assign w_We = (r_State == EXPAND) && (r_Round == 4'(gi));
        assign w_D  = w_Next;
      end

      always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
          r_Slot <= '0;
        end else if (w_We) begin
          r_Slot <= w_D;
        end
      end

      assign o_Key[1407-128*gi -: 128] = r_Slot;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State  <= IDLE;
      r_Round  <= 4'd0;
      r_Rcon   <= 8'h00;
      r_Prev   <= '0;
      r_fBusy  <= 1'b0;
      r_fDone  <= 1'b0;
`ifdef KEY_EXPAND_CACHE_EN
      r_fValid <= 1'b0;
`endif
    end else begin
      case (r_State)
        IDLE: begin
          if (i_fStart) begin
            r_fBusy <= 1'b1;
            if (w_Hit) begin
              r_State <= DONE;
              r_fDone <= 1'b1;
            end else begin
              r_State <= EXPAND;
              r_Round <= 4'd1;
              r_Rcon  <= 8'h01;
              r_Prev  <= i_Key;
`ifdef KEY_EXPAND_CACHE_EN
              // Slot 0 is being replaced, so the cached schedule is stale.
              r_fValid <= 1'b0;
`endif
            end
          end
        end

        EXPAND: begin
          r_Prev <= w_Next;
          r_Rcon <= w_RconNext;
          if (r_Round == 4'd10) begin
            // Round counter parks at 10; it is reloaded on the next start.
            r_State <= DONE;
            r_fDone <= 1'b1;
          end else begin
            r_Round <= r_Round + 4'd1;
          end
        end

        DONE: begin
          r_State <= IDLE;
          r_fDone <= 1'b0;
          r_fBusy <= 1'b0;
`ifdef KEY_EXPAND_CACHE_EN
          r_fValid <= 1'b1;
`endif
        end

        default: begin
          r_State <= IDLE;
          r_fDone <= 1'b0;
          r_fBusy <= 1'b0;
        end
      endcase
    end
  end

  assign o_fBusy = r_fBusy;
  assign o_fDone = r_fDone;

endmodule

// File: tb/tb_key_expand.sv
// -----------------------------------------------------------------------------
// tb_key_expand -- scoreboard bench for key_expand
//
// The driver pushes the expected slots 0, 1 and 10 plus the cycle at which
// o_fDone must appear; a separate monitor pops and compares on every o_fDone.
// -----------------------------------------------------------------------------
module tb_key_expand;

  logic          i_Clk = 1'b0;
  logic          i_Rst = 1'b0;
  logic [127:0]  i_Key = '0;
  logic          i_fStart = 1'b0;
  logic [1407:0] o_Key;
  logic          o_fBusy;
  logic          o_fDone;

  key_expand dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Key    (i_Key),
    .i_fStart (i_fStart),
    .o_Key    (o_Key),
    .o_fBusy  (o_fBusy),
    .o_fDone  (o_fDone)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  // FIPS-197 reference values
  localparam logic [127:0] KA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ  = 128'h0;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef KEY_EXPAND_CACHE_EN
  localparam int REP_LAT  = 0;   // cached repeat: o_fDone right after the start edge
  localparam int HOLD_GAP = 2;   // held start: later starts hit the cache
`else
  localparam int REP_LAT  = 10;
  localparam int HOLD_GAP = 12;
`endif

  typedef struct {
    logic [127:0] k;
    logic [127:0] s1;
    logic [127:0] s10;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [1407:0] act, input logic [1407:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor / scoreboard
  always @(negedge i_Clk) begin
    if (i_Rst && o_fDone) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: o_fDone at cycle %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("slot0",      o_Key[1407:1280], e.k);
        check("slot1",      o_Key[1279:1152], e.s1);
        check("slot10",     o_Key[127:0],     e.s10);
        check("done_cycle", cyc,              e.cyc);
        $display("txn key=%h done_cycle=%0d expected_cycle=%0d", e.k, cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    @(negedge i_Clk);
    for (int i = 0; i < 40 && o_fBusy; i++) @(negedge i_Clk);
  endtask

  // Returns at the negedge right after the start edge.
  task automatic issue(input logic [127:0] key, input logic [127:0] s1,
                       input logic [127:0] s10, input int lat);
    exp_t e;
    wait_idle();
    e.k = key; e.s1 = s1; e.s10 = s10; e.cyc = cyc + 1 + lat;
    q.push_back(e);
    i_Key    = key;
    i_fStart = 1'b1;
    @(negedge i_Clk);
    i_fStart = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge i_Clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      $display("FAIL done_timeout: no o_fDone for key %h, expected at cycle %0d", e.k, e.cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge i_Clk);
    check("rst_key",  o_Key,   '0);
    check("rst_busy", o_fBusy, 1'b0);
    check("rst_done", o_fDone, 1'b0);
    i_Rst = 1'b1;

    // FIPS-197 key and all-zero key
    issue(KA, A1, A10, 10);
    drain();
    issue(KZ, Z1, Z10, 10);
    drain();

    // i_Key changes one cycle after the start edge: result is still key A
    issue(KA, A1, A10, 10);
    i_Key = KZ;
    drain();

    // Repeat of the same key, then a new key
    issue(KA, A1, A10, REP_LAT);
    drain();
    issue(KZ, Z1, Z10, 10);
    drain();

    // Reset in the middle of an expansion
    wait_idle();
    i_Key    = KA;
    i_fStart = 1'b1;
    @(negedge i_Clk);
    i_fStart = 1'b0;
    repeat (4) @(negedge i_Clk);
    #2 i_Rst = 1'b0;
    #1;
    check("midrst_key",  o_Key,   '0);
    check("midrst_busy", o_fBusy, 1'b0);
    check("midrst_done", o_fDone, 1'b0);
    @(negedge i_Clk);
    i_Rst = 1'b1;
    issue(KA, A1, A10, 10);
    drain();

    // i_fStart held high: o_fDone at a fixed spacing, no start taken while busy
    wait_idle();
    begin
      exp_t e;
      int   c0;
      c0 = cyc;
      for (int n = 0; n < 3; n++) begin
        e.k = KZ; e.s1 = Z1; e.s10 = Z10; e.cyc = c0 + 11 + n * HOLD_GAP;
        q.push_back(e);
      end
      i_Key    = KZ;
      i_fStart = 1'b1;
      for (int i = 0; i < 100 && cyc < c0 + 11 + 2 * HOLD_GAP; i++) @(negedge i_Clk);
      i_fStart = 1'b0;
    end
    drain();
    repeat (15) @(negedge i_Clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
